id_operand_fetch: RTL and testbench

- ID-stage register-file reader; the consumer side of the writeback port (RF_wen / RF_waddr / RF_wdata) driven from MEM/WB.
- Holds the 32x32 GPR array with two combinational read ports and a write-to-read bypass from the writeback port.
- Keeps a per-register pending-write scoreboard so ID stalls until every older in-flight writer of a source register has retired.

---
 rtl/id_operand_fetch.sv | 96 +++++++++
 tb/tb_id_operand_fetch.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/id_operand_fetch.sv
// ID-stage operand fetch: 32x32 GPR file with two bypassed read ports and a
// per-register pending-write scoreboard that stalls ID on RAW hazards.
module id_operand_fetch #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        rs_used,
  input  logic        rt_used,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        issue_valid,
  input  logic        issue_wen,
  input  logic [4:0]  issue_waddr,
  output logic        issue_fire,
  output logic        stall,
  input  logic        wb_wen,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        flush
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntFull = {CNT_W{1'b1}};

  logic [31:0]      gpr_q [32];
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];

  logic rs_wb_hit, rt_wb_hit, dst_wb_hit;
  logic rs_haz, rt_haz, cap_haz;

  // GPR array write port; entry 0 is never written and never read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (wb_wen && (wb_waddr != 5'd0)) begin
      gpr_q[wb_waddr] <= wb_wdata;
    end
  end

  // Read ports: r0 is hardwired zero, a same-cycle writeback wins over the array.
  always_comb begin
    rs_wb_hit = wb_wen && (wb_waddr == rs);
    rt_wb_hit = wb_wen && (wb_waddr == rt);
    if (rs == 5'd0)     rdata1 = '0;
    else if (rs_wb_hit) rdata1 = wb_wdata;
    else                rdata1 = gpr_q[rs];
    if (rt == 5'd0)     rdata2 = '0;
    else if (rt_wb_hit) rdata2 = wb_wdata;
    else                rdata2 = gpr_q[rt];
  end

  // Hazard detection and issue handshake.
  always_comb begin
    dst_wb_hit = wb_wen && (wb_waddr == issue_waddr);
    // cnt==1 with a matching writeback is covered by the bypass.
    rs_haz = rs_used && (rs != 5'd0) &&
             ((cnt_q[rs] > CntOne) || ((cnt_q[rs] == CntOne) && !rs_wb_hit));
    rt_haz = rt_used && (rt != 5'd0) &&
             ((cnt_q[rt] > CntOne) || ((cnt_q[rt] == CntOne) && !rt_wb_hit));
    cap_haz = issue_wen && (issue_waddr != 5'd0) &&
              (cnt_q[issue_waddr] == CntFull) && !dst_wb_hit;
    stall      = issue_valid && (rs_haz || rt_haz || cap_haz);
    issue_fire = issue_valid && !stall;
  end

  // Scoreboard next state: increment on issue, decrement on retire, flush wins.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      logic inc, dec;
      cnt_d[i] = cnt_q[i];
      inc = issue_fire && issue_wen && (i != 0) && (issue_waddr == 5'(i));
      dec = wb_wen && (wb_waddr == 5'(i));
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch: reads, bypass, RAW stalls, capacity,
// flush and asynchronous reset.
module tb_id_operand_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rs, rt;
  logic        rs_used, rt_used;
  logic [31:0] rdata1, rdata2;
  logic        issue_valid, issue_wen;
  logic [4:0]  issue_waddr;
  logic        issue_fire, stall;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;

  int n_chk  = 0;
  int n_fail = 0;

  id_operand_fetch #(.CNT_W(2)) dut (
    .clk(clk), .resetn(resetn), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
    .rdata1(rdata1), .rdata2(rdata2), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .issue_fire(issue_fire), .stall(stall), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_wen = en; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic iss(input logic v, input logic w, input logic [4:0] a);
    issue_valid = v; issue_wen = w; issue_waddr = a;
  endtask

  initial begin
    resetn = 1'b0; rs = '0; rt = '0; rs_used = 0; rt_used = 0;
    iss(0, 0, 0); wb(0, 0, 0); flush = 0;
    #12;
    // Reset state
    rs = 5; rt = 9; #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_fire", 32'(issue_fire), 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    chk("reset_rdata2", rdata2, 32'd0);
    resetn = 1'b1;
    tick();

    // Write r5 (cnt[5]=0 so saturates at 0), bypassed in the same cycle
    wb(1, 5, 32'hDEADBEEF); rs = 5; #1;
    chk("wr5_bypass", rdata1, 32'hDEADBEEF);
    tick();
    wb(0, 0, 0); #1;
    chk("wr5_array", rdata1, 32'hDEADBEEF);
    issue_valid = 1; rs_used = 1; #1;
    chk("wr5_no_stall", 32'(stall), 32'd0);
    issue_valid = 0; rs_used = 0;

    // Writes to r0 are ignored
    wb(1, 0, 32'h1234); rs = 0; #1;
    chk("r0_same_cycle", rdata1, 32'd0);
    tick();
    wb(0, 0, 0); #1;
    chk("r0_after", rdata1, 32'd0);

    // Bypass on port 2
    wb(1, 7, 32'hA5A5A5A5); rt = 7; #1;
    chk("byp_rdata2", rdata2, 32'hA5A5A5A5);
    tick();
    wb(0, 0, 0); #1;
    chk("byp_array", rdata2, 32'hA5A5A5A5);

    // RAW stall on r3
    iss(1, 1, 3); #1;
    chk("raw_w_fire", 32'(issue_fire), 32'd1);
    tick();
    iss(1, 0, 0); rs = 3; rs_used = 1; #1;
    chk("raw_stall0", 32'(stall), 32'd1);
    chk("raw_nofire", 32'(issue_fire), 32'd0);
    tick(); #1;
    chk("raw_stall1", 32'(stall), 32'd1);
    wb(1, 3, 32'h33333333); #1;
    chk("raw_wb_stall", 32'(stall), 32'd0);
    chk("raw_wb_fire", 32'(issue_fire), 32'd1);
    chk("raw_wb_data", rdata1, 32'h33333333);
    tick();
    wb(0, 0, 0); #1;
    chk("raw_cnt0", 32'(stall), 32'd0);
    chk("raw_rdata1", rdata1, 32'h33333333);

    // Two writers to r9
    rs_used = 0; iss(1, 1, 9);
    tick(); tick();
    iss(1, 0, 0); rs = 9; rs_used = 1; #1;
    chk("r9_cnt2_stall", 32'(stall), 32'd1);
    wb(1, 9, 32'h99); #1;
    chk("r9_first_wb", 32'(stall), 32'd1);
    tick();
    wb(0, 0, 0); #1;
    chk("r9_cnt1_stall", 32'(stall), 32'd1);
    rs_used = 0; #1;
    chk("r9_unused", 32'(stall), 32'd0);
    rs_used = 1; wb(1, 9, 32'h999); #1;
    chk("r9_second_wb", 32'(stall), 32'd0);
    tick();
    wb(0, 0, 0); #1;
    chk("r9_cnt0", 32'(stall), 32'd0);
    rs_used = 0;

    // Capacity on r4
    iss(1, 1, 4);
    tick(); tick(); tick(); #1;
    chk("cap_full_stall", 32'(stall), 32'd1);
    wb(1, 4, 32'h44); #1;
    chk("cap_wb_stall", 32'(stall), 32'd0);
    chk("cap_wb_fire", 32'(issue_fire), 32'd1);
    tick();
    wb(0, 0, 0); #1;
    chk("cap_unchanged", 32'(stall), 32'd1);
    iss(0, 0, 0); wb(1, 4, 32'h45);
    tick();
    wb(0, 0, 0); iss(1, 1, 4); #1;
    chk("cap_cnt2_fire", 32'(issue_fire), 32'd1);
    iss(1, 0, 0); rt = 4; rt_used = 1; #1;
    chk("rt_cnt2_stall", 32'(stall), 32'd1);
    rt_used = 0;

    // Flush with cnt[3]=2, a same-cycle issue to r3 and a GPR write
    iss(1, 1, 3);
    tick(); tick();
    flush = 1; wb(1, 10, 32'h1010); #1;
    chk("flush_fire", 32'(issue_fire), 32'd1);
    tick();
    flush = 0; wb(0, 0, 0); iss(1, 0, 0);
    rs = 3; rs_used = 1; rt = 4; rt_used = 1; #1;
    chk("flush_stall", 32'(stall), 32'd0);
    rt = 10; #1;
    chk("flush_gpr_wr", rdata2, 32'h1010);
    rt_used = 0;

    // Async reset during a stall
    iss(1, 1, 3); rs_used = 0;
    tick();
    iss(1, 0, 0); rs = 3; rs_used = 1; rt = 5; #1;
    chk("rst_pre_stall", 32'(stall), 32'd1);
    chk("rst_pre_r5", rdata2, 32'hDEADBEEF);
    resetn = 0; #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_r5", rdata2, 32'd0);
    chk("rst_r3", rdata1, 32'd0);
    resetn = 1;
    tick(); #1;
    chk("rst_after_stall", 32'(stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
